// File: rtl/iter_shifter_pkg.sv
// Shared constants for the iterative shifter: shift-type encoding, FSM states, shamt width.
// The shift-type encoding is the same one the combinational ALU shifter uses.
package iter_shifter_pkg;

    localparam int SHAMT_W = 5;

    localparam logic [1:0] SHIFT_SRL  = 2'b00;
    localparam logic [1:0] SHIFT_SLL  = 2'b01;
    localparam logic [1:0] SHIFT_SRA  = 2'b10;
    localparam logic [1:0] SHIFT_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/iter_shifter_if.sv
// Operand/result handshake bundle between the execute stage and the iterative shifter.
// The master side is the pipeline (producer and consumer). The slave side is the shifter.
interface iter_shifter_if #(parameter int N = 32);
    import iter_shifter_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       a;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         shift_type;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       r;

    modport master (
        output in_valid, a, shamt, shift_type, out_ready,
        input  in_ready, out_valid, r
    );

    modport slave (
        input  in_valid, a, shamt, shift_type, out_ready,
        output in_ready, out_valid, r
    );

endinterface

// File: rtl/iter_shift_step.sv
// One shift iteration: moves data by k bits (k is at most STEP) in the requested direction.
// SRA fills from data[N-1], which still holds the original sign bit on every step.
module iter_shift_step
    import iter_shifter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]       data,
    input  logic [SHAMT_W-1:0] k,
    input  logic [1:0]         shift_type,
    output logic [N-1:0]       result
);

    always_comb begin
        result = data;
        case (shift_type)
            SHIFT_SRL: result = data >> k;
            SHIFT_SLL: result = data << k;
            SHIFT_SRA: result = $signed(data) >>> k;
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift unit: it shifts by up to STEP bits per clock and uses valid/ready on both sides.
// A flush returns the unit to IDLE. The data register is left stale, and the result is hidden because out_valid is low.
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    iter_shifter_if.slave bus
);

    localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

    state_t             state;
    logic [N-1:0]       data;
    logic [SHAMT_W-1:0] count;
    logic [1:0]         type_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [SHAMT_W-1:0] k;
    logic [SHAMT_W-1:0] next_count;
    logic [N-1:0]       shifted;

    // The final iteration moves only the bits that remain, so the total always equals shamt.
    assign k          = (count < STEP_K) ? count : STEP_K;
    assign next_count = count - k;

    iter_shift_step #(.N(N)) u_step (
        .data       (data),
        .k          (k),
        .shift_type (type_q),
        .result     (shifted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            data        <= '0;
            count       <= '0;
            type_q      <= SHIFT_SRL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data       <= bus.a;
                        type_q     <= bus.shift_type;
                        in_ready_q <= 1'b0;
                        if (bus.shift_type == SHIFT_PASS || bus.shamt == '0) begin
                            count       <= '0;
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            count <= bus.shamt;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data  <= shifted;
                    count <= next_count;
                    if (next_count == '0) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.r         = data;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench: four shifters (STEP = 1, 2, 4, 8) are checked every cycle against a latency/barrel-shift model.
// Directed cases pin exact latencies and literal results. A random sweep then covers operands, types and backpressure.
module tb_iter_shifter;

    localparam int NI = 4;

    logic clk;
    logic rst;
    logic flush;

    logic [NI-1:0]       in_valid;
    logic [NI-1:0]       out_ready;
    logic [NI-1:0][31:0] a;
    logic [NI-1:0][4:0]  shamt;
    logic [NI-1:0][1:0]  typ;
    logic [NI-1:0]       in_ready;
    logic [NI-1:0]       out_valid;
    logic [NI-1:0][31:0] r;

    int checks;
    int failures;
    int cyc;

    // Instance g shifts by (1 << g) bits per cycle.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        iter_shifter_if #(.N(32)) bus ();
        assign bus.in_valid   = in_valid[g];
        assign bus.a          = a[g];
        assign bus.shamt      = shamt[g];
        assign bus.shift_type = typ[g];
        assign bus.out_ready  = out_ready[g];
        assign in_ready[g]    = bus.in_ready;
        assign out_valid[g]   = bus.out_valid;
        assign r[g]           = bus.r;

        iter_shifter #(.N(32), .STEP(1 << g)) dut (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .bus   (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each instance is idle, busy for a known number of edges, or holding a result.
    int          m_phase [NI];
    int          m_wait  [NI];
    logic [31:0] m_r     [NI];

    function automatic logic [31:0] barrel(input logic [31:0] v, input logic [4:0] s, input logic [1:0] t);
        case (t)
            2'b00:   return v >> s;
            2'b01:   return v << s;
            2'b10:   return $signed(v) >>> s;
            default: return v;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                m_phase[i] <= 0;
                m_wait[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                int step;
                int w;
                step = 1 << i;
                w    = (typ[i] == 2'b11) ? 0 : (int'(shamt[i]) + step - 1) / step;
                if (flush) begin
                    m_phase[i] <= 0;
                end else if (m_phase[i] == 0) begin
                    if (in_valid[i]) begin
                        m_r[i]     <= barrel(a[i], shamt[i], typ[i]);
                        m_wait[i]  <= w;
                        m_phase[i] <= (w == 0) ? 2 : 1;
                    end
                end else if (m_phase[i] == 1) begin
                    m_wait[i] <= m_wait[i] - 1;
                    if (m_wait[i] == 1) m_phase[i] <= 2;
                end else if (out_ready[i]) begin
                    m_phase[i] <= 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic compareCycle();
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                checkOutput($sformatf("model_in_ready[%0d]", i), 32'(in_ready[i]), 32'(m_phase[i] == 0));
                checkOutput($sformatf("model_out_valid[%0d]", i), 32'(out_valid[i]), 32'(m_phase[i] == 2));
                if (m_phase[i] == 2)
                    checkOutput($sformatf("model_r[%0d]", i), r[i], m_r[i]);
            end
        end
    endtask

    // Advance one clock. Outputs are compared on the falling edge, and control returns 2 time units after the rising edge.
    task automatic tick();
        @(negedge clk);
        compareCycle();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic applyStimulus(input logic [NI-1:0] mask, input logic [31:0] av,
                                 input logic [4:0] sv, input logic [1:0] tv);
        int n;
        n = 0;
        for (int i = 0; i < NI; i++) begin
            if (mask[i]) begin
                a[i]        = av;
                shamt[i]    = sv;
                typ[i]      = tv;
                in_valid[i] = 1'b1;
            end
        end
        while ((in_ready & mask) != mask && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) checkOutput("accept_timeout", 32'(in_ready & mask), 32'(mask));
        tick();
        in_valid = in_valid & ~mask;
    endtask

    task automatic waitValid(input int i, output int n);
        n = 1;
        while (!out_valid[i] && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic seen;

        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = '0;
        out_ready = '1;
        a         = '0;
        shamt     = '0;
        typ       = '0;

        // The reset values must appear before any clock edge arrives.
        #3;
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("reset_in_ready[%0d]", i), 32'(in_ready[i]), 32'd1);
            checkOutput($sformatf("reset_out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
            checkOutput($sformatf("reset_r[%0d]", i), r[i], 32'd0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick();

        applyStimulus(4'b0001, 32'h0000_0001, 5'd5, 2'b01);
        waitValid(0, n);
        checkOutput("sll_latency", 32'(n), 32'd6);
        checkOutput("sll_r", r[0], 32'h0000_0020);
        tick();
        checkOutput("sll_in_ready_after", 32'(in_ready[0]), 32'd1);
        checkOutput("sll_out_valid_after", 32'(out_valid[0]), 32'd0);

        applyStimulus(4'b0100, 32'h8000_0000, 5'd31, 2'b10);
        waitValid(2, n);
        checkOutput("sra_step4_latency", 32'(n), 32'd9);
        checkOutput("sra_step4_r", r[2], 32'hFFFF_FFFF);
        tick();
        applyStimulus(4'b0100, 32'h8000_0000, 5'd31, 2'b00);
        waitValid(2, n);
        checkOutput("srl_step4_latency", 32'(n), 32'd9);
        checkOutput("srl_step4_r", r[2], 32'h0000_0001);
        tick();

        applyStimulus(4'b1111, 32'h8000_0000, 5'd0, 2'b00);
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("shamt0_valid[%0d]", i), 32'(out_valid[i]), 32'd1);
            checkOutput($sformatf("shamt0_r[%0d]", i), r[i], 32'h8000_0000);
        end
        tick();
        applyStimulus(4'b1111, 32'h1234_5678, 5'd7, 2'b11);
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("pass_valid[%0d]", i), 32'(out_valid[i]), 32'd1);
            checkOutput($sformatf("pass_r[%0d]", i), r[i], 32'h1234_5678);
        end
        tick();

        // Backpressure: inputs change mid-operation, and the result must then be held while the consumer stalls.
        out_ready[0] = 1'b0;
        applyStimulus(4'b0001, 32'h0000_000F, 5'd4, 2'b01);
        a[0]   = 32'hDEAD_BEEF;
        typ[0] = 2'b10;
        waitValid(0, n);
        checkOutput("bp_latency", 32'(n), 32'd5);
        for (int k = 0; k < 3; k++) begin
            checkOutput("bp_r", r[0], 32'h0000_00F0);
            checkOutput("bp_out_valid", 32'(out_valid[0]), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready[0]), 32'd0);
            tick();
        end
        out_ready[0] = 1'b1;
        tick();
        checkOutput("bp_release_in_ready", 32'(in_ready[0]), 32'd1);

        applyStimulus(4'b0001, 32'hA5A5_A5A5, 5'd20, 2'b00);
        for (int k = 0; k < 4; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_shift_in_ready", 32'(in_ready[0]), 32'd1);
        checkOutput("flush_shift_out_valid", 32'(out_valid[0]), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            seen = seen | out_valid[0];
            tick();
        end
        checkOutput("flush_no_late_valid", 32'(seen), 32'd0);

        out_ready[0] = 1'b0;
        applyStimulus(4'b0001, 32'h0F0F_0F0F, 5'd0, 2'b00);
        flush        = 1'b1;
        out_ready[0] = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_done_in_ready", 32'(in_ready[0]), 32'd1);
        checkOutput("flush_done_out_valid", 32'(out_valid[0]), 32'd0);

        // Pulse the reset between clock edges while the unit is mid-shift.
        applyStimulus(4'b0001, 32'h1357_9BDF, 5'd20, 2'b01);
        for (int k = 0; k < 3; k++) tick();
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_mid_in_ready", 32'(in_ready[0]), 32'd1);
        checkOutput("rst_mid_out_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("rst_mid_r", r[0], 32'd0);
        rst = 1'b0;
        tick();

        for (int it = 0; it < 160; it++) begin
            logic [1:0] t;
            t = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            applyStimulus(4'b1111, $urandom, 5'($urandom_range(0, 31)), t);
            n = 0;
            while (in_ready != 4'b1111 && n < 200) begin
                out_ready = 4'($urandom);
                for (int i = 0; i < NI; i++) begin
                    a[i]   = $urandom;
                    typ[i] = 2'($urandom);
                end
                tick();
                n++;
            end
            if (n >= 200) checkOutput("sweep_timeout", 32'(in_ready), 32'hF);
            out_ready = '1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
Multi-cycle iterative shift unit for the execute stage. It performs SLL/SRL/SRA by STEP bits per clock instead of using a full barrel network, which trades latency for area. A valid/ready handshake on both sides lets the pipeline hazard logic stall on it. It uses the same shift-type encoding as the combinational ALU shifter.

Parameters:
N, 32, operand/result width (shamt width fixed at 5; N must be 32)
STEP, 1, bits shifted per cycle; legal values 1, 2, 4, 8

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous abort of any operation in flight
in_valid  input  1  operand presented
in_ready  output  1  unit can accept an operand
a  input  N  operand to shift
shamt  input  5  shift amount
type  input  2  00=SRL, 01=SLL, 10=SRA, 11=pass-through (r=a)
out_valid  output  1  result available
out_ready  input  1  consumer takes result
r  output  N  shifted result

Behaviour:
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE; r is driven from the data register.
- Reset (async, rst=1): state=IDLE, data=0, count=0, type register=00, out_valid=0, r=0, in_ready=1. These take effect immediately, without waiting for a clock edge, including mid-operation.
- Accept: a rising edge with state=IDLE && in_valid.
  - Latch a, type and count=shamt. Type 11 forces count=0.
  - Next state is SHIFT if count!=0, otherwise DONE.
- SHIFT, per edge: let k=min(STEP,count).
  - SLL: data<<k, zero fill. SRL: data>>k, zero fill. SRA: data>>>k, filling with data[N-1], which equals the original sign bit.
  - count-=k. When the new count==0, next state is DONE.
- Latency from the accept edge to out_valid high is 1+ceil(shamt/STEP) cycles; type 11 or shamt=0 gives 1 cycle.
- DONE: hold r and out_valid stable while out_ready=0. On an edge with out_ready=1, go to IDLE; in_ready rises in the following cycle. There is no accept in the same cycle as the output handshake.
- Inputs a/shamt/type are ignored outside the accept edge. Changes after accept do not affect the result.
- flush=1 at an edge, in any state:
  - Next state is IDLE and out_valid drops.
  - count and data are left don't-care, but r must not show a spurious out_valid.
  - flush has priority over accept and over the output handshake.
- in_valid while busy: no effect. The producer must hold in_valid until in_ready.
- Result is bit-exact with a single-cycle barrel shift of the same a/shamt/type.

Decomposition:
- Shared package holds:
  - shift-type constants SHIFT_SRL=2'b00, SHIFT_SLL=2'b01, SHIFT_SRA=2'b10, SHIFT_PASS=2'b11;
  - state encoding IDLE/SHIFT/DONE;
  - localparam for shamt width (5).
- One natural sub-module: iter_shift_step.
  - Purely combinational: data, k (0..STEP), type -> shifted data.
  - Has a default case so it is latch-free.
  - The FSM/count/handshake stays in iter_shifter.

Test Plan:
1. STEP=1, SLL a=0x00000001 shamt=5, out_ready=1 -> out_valid exactly 6 cycles after accept, r=0x00000020, in_ready=1 one cycle after the handshake.
2. STEP=4, SRA a=0x80000000 shamt=31 -> latency 9 cycles (8 SHIFT cycles, last k=3), r=0xFFFFFFFF; repeat with SRL -> r=0x00000001.
3. shamt=0 SRL a=0x80000000 -> out_valid 1 cycle after accept, r=0x80000000; type=11 shamt=7 a=0x12345678 -> 1 cycle, r=0x12345678.
4. Backpressure: SLL a=0x0000000F shamt=4, out_ready=0 for 3 cycles in DONE -> r=0x000000F0 stable, out_valid=1, in_ready=0; raise out_ready -> IDLE next cycle. Change a/type during SHIFT -> result unaffected.
5. Abort cases:
   - flush during SHIFT (STEP=1, shamt=20, cycle 5) -> next cycle IDLE, in_ready=1, out_valid never asserted.
   - flush and out_ready both high in DONE -> IDLE.
   - rst pulsed between clock edges mid-SHIFT -> out_valid=0, r=0, in_ready=1 immediately.
6. Randomized sweep of a, shamt 0..31 and types 00/01/10 for each STEP in {1,2,4,8} -> r matches the reference barrel-shift model, and latency=1+ceil(shamt/STEP).
